// File: rtl/clk_gate_latch.sv
// Single-channel integrated clock gate: an enable latch that is transparent
// while CK is low, feeding an AND with CK. RN clears the latch at any time.
module clk_gate_latch (
    input  logic CK,
    input  logic RN,
    input  logic E,
    input  logic SE,
    output logic GCK,
    output logic EN_Q
);

    logic en_d;
    logic en_l;

    always_comb begin
        en_d = E | SE;
    end

    // Closing on CK high means an enable edge coincident with the CK rise
    // is ignored, so a high phase is always either full or absent.
    always_latch begin
        if (!RN) begin
            en_l <= 1'b0;
        end else if (!CK) begin
            en_l <= en_d;
        end
    end

    assign GCK  = CK & en_l;
    assign EN_Q = en_l;

endmodule

// File: rtl/clk_gate_tst_x1.sv
// Bank of WIDTH independent latch-based clock gates sharing one source clock,
// each enabled by its functional enable ORed with its scan enable.
module clk_gate_tst_x1 #(
    parameter int WIDTH = 1
) (
    input  logic             CK,
    input  logic             RN,
    input  logic [WIDTH-1:0] E,
    input  logic [WIDTH-1:0] SE,
    output logic [WIDTH-1:0] GCK,
    output logic [WIDTH-1:0] EN_Q
);

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_chan
            clk_gate_latch u_gate (
                .CK   (CK),
                .RN   (RN),
                .E    (E[gi]),
                .SE   (SE[gi]),
                .GCK  (GCK[gi]),
                .EN_Q (EN_Q[gi])
            );
        end
    endgenerate

`ifndef SYNTHESIS
    always_comb begin
        if (CK === 1'b0) begin
            assert (GCK === '0) else $error("gated clock high while CK low");
        end
    end

    // GCK = CK & EN_Q, so a latch change inside a high phase is a GCK glitch.
    always @(EN_Q) begin
        if (RN === 1'b1 && CK === 1'b1) begin
            assert (0) else $error("enable latch changed during CK high phase");
        end
    end
`endif

endmodule

// File: tb/tb_clk_gate_tst_x1.sv
// Self-checking bench for clk_gate_tst_x1: directed vector table, hand-written
// reset/free-running sequences and randomized stimulus against a latch model.
module tb_clk_gate_tst_x1;

    localparam int W = 4;

    logic         CK;
    logic         RN;
    logic [W-1:0] E;
    logic [W-1:0] SE;
    wire  [W-1:0] GCK;
    wire  [W-1:0] EN_Q;

    int errors = 0;
    int checks = 0;

    logic [W-1:0] m_en;

    clk_gate_tst_x1 #(.WIDTH(W)) dut (
        .CK   (CK),
        .RN   (RN),
        .E    (E),
        .SE   (SE),
        .GCK  (GCK),
        .EN_Q (EN_Q)
    );

    typedef struct {
        logic         ck;
        logic         rn;
        logic [W-1:0] e;
        logic [W-1:0] se;
        logic [W-1:0] gck;
        logic [W-1:0] enq;
    } vec_t;

    // Reference: the enable is whatever E|SE was during the latest low phase
    // (0 while in reset); the gated clock is that enable during high phases.
    task automatic model_update();
        if (RN !== 1'b1) m_en = '0;
        else if (CK == 1'b0) m_en = E | SE;
    endtask

    function automatic logic [W-1:0] model_gck();
        return CK ? m_en : '0;
    endfunction

    // Clock moves before data so a same-step enable change misses the rise.
    task automatic apply(input logic ck, input logic rn,
                         input logic [W-1:0] e, input logic [W-1:0] se,
                         input int hold);
        RN = rn;
        model_update();
        CK = ck;
        model_update();
        E  = e;
        SE = se;
        model_update();
        #(hold);
    endtask

    task automatic check(input string name, input logic [W-1:0] gck_exp,
                         input logic [W-1:0] enq_exp);
        checks++;
        if (GCK !== gck_exp || EN_Q !== enq_exp) begin
            errors++;
            $display("FAIL %s: got GCK=%b EN_Q=%b, required GCK=%b EN_Q=%b",
                     name, GCK, EN_Q, gck_exp, enq_exp);
        end else begin
            $display("ok   %s: GCK=%b EN_Q=%b", name, GCK, EN_Q);
        end
    endtask

    task automatic check_model(input string name);
        check(name, model_gck(), m_en);
    endtask

    vec_t vecs[$];

    initial begin
        CK = 1'b0; RN = 1'b0; E = '0; SE = '0; m_en = '0;

        // Low phase: latch follows E|SE, GCK held low.
        vecs.push_back('{1'b0, 1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b0000});
        vecs.push_back('{1'b0, 1'b1, 4'b0000, 4'b0001, 4'b0000, 4'b0001});
        vecs.push_back('{1'b0, 1'b1, 4'b0001, 4'b0000, 4'b0000, 4'b0001});
        vecs.push_back('{1'b0, 1'b1, 4'b0001, 4'b0001, 4'b0000, 4'b0001});
        // High phase after enabled low phase: inputs ignored, GCK held 1.
        vecs.push_back('{1'b1, 1'b1, 4'b0000, 4'b0000, 4'b0001, 4'b0001});
        vecs.push_back('{1'b1, 1'b1, 4'b0000, 4'b0001, 4'b0001, 4'b0001});
        vecs.push_back('{1'b1, 1'b1, 4'b0001, 4'b0000, 4'b0001, 4'b0001});
        vecs.push_back('{1'b1, 1'b1, 4'b0001, 4'b0001, 4'b0001, 4'b0001});
        // Disabled low phase, enable raised mid-high: no pulse until next one.
        vecs.push_back('{1'b0, 1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b0000});
        vecs.push_back('{1'b1, 1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b0000});
        vecs.push_back('{1'b1, 1'b1, 4'b0001, 4'b0000, 4'b0000, 4'b0000});
        vecs.push_back('{1'b0, 1'b1, 4'b0001, 4'b0000, 4'b0000, 4'b0001});
        vecs.push_back('{1'b1, 1'b1, 4'b0001, 4'b0000, 4'b0001, 4'b0001});
        // Multi-channel: E and SE mixed across lanes.
        vecs.push_back('{1'b0, 1'b1, 4'b0101, 4'b1000, 4'b0000, 4'b1101});
        vecs.push_back('{1'b1, 1'b1, 4'b0101, 4'b1000, 4'b1101, 4'b1101});
        vecs.push_back('{1'b0, 1'b1, 4'b0101, 4'b1000, 4'b0000, 4'b1101});

        // Reset state, in both CK phases, before any low phase out of reset.
        #3;
        check("reset_ck0", 4'b0000, 4'b0000);
        apply(1'b1, 1'b0, 4'b1111, 4'b1111, 5);
        check("reset_ck1", 4'b0000, 4'b0000);
        apply(1'b1, 1'b1, 4'b1111, 4'b1111, 5);
        check("release_in_high", 4'b0000, 4'b0000);

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i].ck, vecs[i].rn, vecs[i].e, vecs[i].se, 10);
            check($sformatf("vec%0d", i), vecs[i].gck, vecs[i].enq);
        end

        // Free-running CK with SE=1 on lane 0: GCK[0] mirrors CK.
        for (int c = 0; c < 4; c++) begin
            apply(1'b0, 1'b1, 4'b0000, 4'b0001, 5);
            check($sformatf("se_run_lo%0d", c), 4'b0000, 4'b0001);
            apply(1'b1, 1'b1, 4'b0000, 4'b0001, 5);
            check($sformatf("se_run_hi%0d", c), 4'b0001, 4'b0001);
        end
        apply(1'b0, 1'b1, 4'b0000, 4'b0000, 5);
        check("se_off_lo", 4'b0000, 4'b0000);
        apply(1'b1, 1'b1, 4'b0000, 4'b0000, 5);
        check("se_off_hi", 4'b0000, 4'b0000);

        // Reset mid-pulse truncates immediately; release waits for a low phase.
        apply(1'b0, 1'b1, 4'b0001, 4'b0000, 5);
        apply(1'b1, 1'b1, 4'b0001, 4'b0000, 2);
        check("pulse_before_rst", 4'b0001, 4'b0001);
        RN = 1'b0;
        #1;
        check("rst_mid_pulse", 4'b0000, 4'b0000);
        #2;
        RN = 1'b1;
        #1;
        check("rst_release_hi", 4'b0000, 4'b0000);
        apply(1'b0, 1'b1, 4'b0001, 4'b0000, 5);
        check("rst_release_lo", 4'b0000, 4'b0001);
        apply(1'b1, 1'b1, 4'b0001, 4'b0000, 5);
        check("first_pulse", 4'b0001, 4'b0001);

        // Randomized: every half-cycle new E/SE, sometimes a mid-phase change
        // and an occasional reset pulse, compared with the model.
        apply(1'b0, 1'b1, '0, '0, 5);
        for (int n = 0; n < 200; n++) begin
            logic rn_r;
            rn_r = ($urandom_range(0, 19) != 0);
            apply(~CK, rn_r, W'($urandom), W'($urandom), 2);
            check_model($sformatf("rand%0d_a", n));
            if ($urandom_range(0, 1) == 1) begin
                apply(CK, 1'b1, W'($urandom), W'($urandom), 2);
                check_model($sformatf("rand%0d_b", n));
            end else begin
                apply(CK, 1'b1, E, SE, 2);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
